// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants, quadrant encoding and quarter-sine table builder
package dds_pkg;

  localparam int DEF_PHASE_WIDTH    = 16;
  localparam int DEF_LUT_ADDR_WIDTH = 8;
  localparam int DEF_SAMPLE_WIDTH   = 12;

  typedef enum logic [1:0] {
    QUAD_RISE     = 2'd0,
    QUAD_FALL     = 2'd1,
    QUAD_NEG_RISE = 2'd2,
    QUAD_NEG_FALL = 2'd3
  } quadrant_t;

  localparam longint PI_Q30 = 64'sd3373259426;

  // round(A*sin(2*pi*k/N)) in Q30 fixed point; Taylor series to x^15 is exact enough for k <= N/4
  function automatic int quarter_sine(input int k, input int addr_width, input int sample_width);
    longint x, x2, term, acc, amp;
    x    = (longint'(2) * PI_Q30 * k) >>> addr_width;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / ((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    amp = (longint'(1) <<< (sample_width - 1)) - 1;
    return int'((amp * acc + (longint'(1) <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// rtl/sine_quarter_lut.sv - quarter-wave sine table with quadrant mirroring, registered output
module sine_quarter_lut
  import dds_pkg::*;
#(
  parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH,
  parameter int SAMPLE_WIDTH   = DEF_SAMPLE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [LUT_ADDR_WIDTH-1:0] table_index,
  output logic                      sample_valid,
  output logic                      sample_negate,
  output logic [SAMPLE_WIDTH-2:0]   sample_mag,
  output logic [LUT_ADDR_WIDTH-1:0] sample_index
);

  localparam int QN = 1 << (LUT_ADDR_WIDTH - 2);
  localparam int AW = LUT_ADDR_WIDTH - 1;

  logic [SAMPLE_WIDTH-2:0]   rom [0:QN];
  logic [LUT_ADDR_WIDTH-3:0] offset;
  logic [AW-1:0]             addr;
  quadrant_t                 quad;

  for (genvar k = 0; k <= QN; k++) begin : g_rom
    localparam int QV = quarter_sine(k, LUT_ADDR_WIDTH, SAMPLE_WIDTH);
    assign rom[k] = (SAMPLE_WIDTH - 1)'(QV);
  end

  assign quad   = quadrant_t'(table_index[LUT_ADDR_WIDTH-1 -: 2]);
  assign offset = table_index[LUT_ADDR_WIDTH-3:0];
  assign addr   = (quad == QUAD_FALL || quad == QUAD_NEG_FALL) ? AW'(QN) - {1'b0, offset}
                                                               : {1'b0, offset};

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid  <= 1'b0;
      sample_negate <= 1'b0;
      sample_mag    <= '0;
      sample_index  <= '0;
    end else begin
      sample_valid <= load;
      if (load) begin
        sample_mag    <= rom[addr];
        sample_negate <= (quad == QUAD_NEG_RISE) || (quad == QUAD_NEG_FALL);
        sample_index  <= table_index;
      end
    end
  end

endmodule

// File: rtl/dds_bpsk_generator.sv
// rtl/dds_bpsk_generator.sv - DDS carrier with run-time FTW/phase and wrap-synchronous BPSK inversion
module dds_bpsk_generator
  import dds_pkg::*;
#(
  parameter int          PHASE_WIDTH    = DEF_PHASE_WIDTH,
  parameter int          LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH,
  parameter int          SAMPLE_WIDTH   = DEF_SAMPLE_WIDTH,
  parameter int unsigned FTW_RESET      = 1 << (PHASE_WIDTH - LUT_ADDR_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [PHASE_WIDTH-1:0]         cfg_ftw,
  input  logic [PHASE_WIDTH-1:0]         cfg_phase,
  input  logic                           sym_in,
  output logic signed [SAMPLE_WIDTH-1:0] sine_out,
  output logic signed [SAMPLE_WIDTH-1:0] neg_sine_out,
  output logic                           valid_out,
  output logic                           wrap_out,
  output logic [LUT_ADDR_WIDTH-1:0]      phase_cnt
);

  logic [PHASE_WIDTH-1:0]    acc, ftw_act, phase_act, ftw_sh, phase_sh, sym_off;
  logic [PHASE_WIDTH:0]      acc_sum;
  logic                      sym_act, pending, imm_sh, carry, take_cfg, apply_cfg;
  logic                      v1, v2, neg2;
  logic [LUT_ADDR_WIDTH-1:0] idx1, idx2, phase_idx;
  logic [SAMPLE_WIDTH-2:0]   mag2;
  logic signed [SAMPLE_WIDTH-1:0] mag_s;

  assign acc_sum   = {1'b0, acc} + {1'b0, ftw_act};
  assign carry     = en & acc_sum[PHASE_WIDTH];
  assign cfg_ready = ~pending;
  assign take_cfg  = cfg_valid & cfg_ready;
  // a transfer taken while idle applies at once; otherwise it waits for a later wrap
  assign apply_cfg = pending & (imm_sh | carry);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      ftw_act   <= PHASE_WIDTH'(FTW_RESET);
      phase_act <= '0;
      ftw_sh    <= '0;
      phase_sh  <= '0;
      sym_act   <= 1'b0;
      pending   <= 1'b0;
      imm_sh    <= 1'b0;
      wrap_out  <= 1'b0;
    end else begin
      wrap_out <= carry;
      if (en) acc <= acc_sum[PHASE_WIDTH-1:0];
      if (take_cfg) begin
        ftw_sh   <= cfg_ftw;
        phase_sh <= cfg_phase;
        imm_sh   <= ~en;
        pending  <= 1'b1;
      end else if (apply_cfg) begin
        ftw_act   <= ftw_sh;
        phase_act <= phase_sh;
        pending   <= 1'b0;
      end
      if (carry || apply_cfg) sym_act <= sym_in;
    end
  end

  assign sym_off   = {sym_act, {(PHASE_WIDTH - 1){1'b0}}};
  assign phase_idx = LUT_ADDR_WIDTH'((acc + phase_act + sym_off) >> (PHASE_WIDTH - LUT_ADDR_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      idx1 <= '0;
    end else begin
      v1 <= en;
      if (en) idx1 <= phase_idx;
    end
  end

  sine_quarter_lut #(
    .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH),
    .SAMPLE_WIDTH  (SAMPLE_WIDTH)
  ) u_lut (
    .clk          (clk),
    .rst          (rst),
    .load         (v1),
    .table_index  (idx1),
    .sample_valid (v2),
    .sample_negate(neg2),
    .sample_mag   (mag2),
    .sample_index (idx2)
  );

  assign mag_s = {1'b0, mag2};

  always_ff @(posedge clk) begin
    if (rst) begin
      sine_out     <= '0;
      neg_sine_out <= '0;
      valid_out    <= 1'b0;
      phase_cnt    <= '0;
    end else begin
      valid_out <= v2;
      if (v2) begin
        sine_out     <= neg2 ? -mag_s : mag_s;
        neg_sine_out <= neg2 ? mag_s : -mag_s;
        phase_cnt    <= idx2;
      end
    end
  end

endmodule
